bp_reg_initiator: RTL

//  Host-side initiator for the BytePipe register protocol (the responder side is bpReg/bpCorrelator).

---
 rtl/bp_pkg.sv | 26 ++
 rtl/bp_reg_initiator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BytePipe register-protocol initiator: FSM states,
// wire-format field positions and the command-byte packer.
package bp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT,
    RSP
  } bp_state_e;

  localparam int BP_WR_BIT = 7;
  localparam int BP_ADDR_W = 7;
  localparam int BP_DATA_W = 8;

  function automatic logic [BP_DATA_W-1:0] bp_cmd_byte(input logic                 wr,
                                                        input logic [BP_ADDR_W-1:0] addr);
    logic [BP_DATA_W-1:0] b;
    b                = '0;
    b[BP_ADDR_W-1:0] = addr;
    b[BP_WR_BIT]     = wr;
    return b;
  endfunction

endpackage

// File: rtl/bp_reg_initiator.sv
// BytePipe register initiator: serialises one read/write request into command bytes,
// waits (with timeout) for the single reply byte and presents it as a response.
module bp_reg_initiator
  import bp_pkg::*;
#(
  parameter int TIMEOUT_EXP = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wr,
  input  logic [BP_ADDR_W-1:0] i_req_addr,
  input  logic [BP_DATA_W-1:0] i_req_wdata,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [BP_DATA_W-1:0] o_rsp_rdata,
  output logic                 o_rsp_timeout,
  output logic [BP_DATA_W-1:0] o_bp_data,
  output logic                 o_bp_valid,
  input  logic                 i_bp_ready,
  input  logic [BP_DATA_W-1:0] i_bp_data,
  input  logic                 i_bp_valid,
  output logic                 o_bp_ready,
  output logic [7:0]           o_nDiscard
);

  localparam logic [TIMEOUT_EXP-1:0] TCTR_ONE = {{(TIMEOUT_EXP-1){1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  bp_state_e              state_q, state_d;
  logic                   wr_q, wr_d;
  logic [BP_ADDR_W-1:0]   addr_q, addr_d;
  logic [BP_DATA_W-1:0]   wdata_q, wdata_d;
  logic [BP_DATA_W-1:0]   rdata_q, rdata_d;
  logic                   timeout_q, timeout_d;
  logic [TIMEOUT_EXP-1:0] tctr_q, tctr_d;
  logic [7:0]             ndisc_q, ndisc_d;

  logic req_hs, out_hs, in_hs, rsp_hs;

  // All outputs are decoded from registered state only, never from a ready input.
  assign o_req_ready   = (state_q == IDLE);
  assign o_bp_valid    = (state_q == ADDR) || (state_q == DATA);
  assign o_bp_ready    = (state_q == IDLE) || (state_q == WAIT);
  assign o_rsp_valid   = (state_q == RSP);
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_timeout = timeout_q;
  assign o_nDiscard    = ndisc_q;

  always_comb begin
    o_bp_data = '0;
    case (state_q)
      ADDR:    o_bp_data = bp_cmd_byte(wr_q, addr_q);
      DATA:    o_bp_data = wdata_q;
      default: o_bp_data = '0;
    endcase
  end

  assign req_hs = i_cg & i_req_valid & o_req_ready;
  assign out_hs = i_cg & o_bp_valid & i_bp_ready;
  assign in_hs  = i_cg & i_bp_valid & o_bp_ready;
  assign rsp_hs = i_cg & o_rsp_valid & i_rsp_ready;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    tctr_d    = tctr_q;
    ndisc_d   = ndisc_q;
    case (state_q)
      IDLE: begin
        // Anything arriving here is a stray or a reply that lost the race with the timeout.
        if (in_hs) ndisc_d = sat_inc8(ndisc_q);
        if (req_hs) begin
          wr_d    = i_req_wr;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (out_hs) state_d = wr_q ? DATA : WAIT;
      end
      DATA: begin
        if (out_hs) state_d = WAIT;
      end
      WAIT: begin
        if (i_cg) begin
          if (in_hs) begin
            rdata_d   = i_bp_data;
            timeout_d = 1'b0;
            tctr_d    = '0;
            state_d   = RSP;
          end else if (tctr_q == '1) begin
            rdata_d   = '0;
            timeout_d = 1'b1;
            tctr_d    = '0;
            state_d   = RSP;
          end else begin
            tctr_d = tctr_q + TCTR_ONE;
          end
        end
      end
      RSP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      tctr_q    <= '0;
      ndisc_q   <= '0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      tctr_q    <= tctr_d;
      ndisc_q   <= ndisc_d;
    end
  end

  // Request fields are only consumed after being latched, so they need no reset.
  always_ff @(posedge i_clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule
